result_monitor: RTL and testbench

Parametrised successor to the fixed-function write checker in the CHIP testbench. It snoops the processor's D-cache write stream (word address, data, write enable) and compares it against a loadable table of expected (address, data) pairs. It reports a saturating error count, a run duration, `finish` and `timeout`. It supports in-order and any-order checking, a configurable end-marker address and a cycle timeout, and it is synthesizable so it can also sit on-chip as a self-test monitor.

---
 rtl/result_monitor_pkg.sv | 21 ++
 rtl/result_monitor_match_cam.sv | 53 +++++
 rtl/result_monitor.sv | 153 +++++++++++++++
 tb/tb_result_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_monitor_pkg.sv
// Shared types and helpers for the result monitor: run-state encoding and a
// saturating accumulator used for every error-count update.
package result_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    // Widths up to 32 bits; callers cast in and out of their own width.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/result_monitor_match_cam.sv
// Associative address match for any-order checking: lowest-index unmatched entry
// with an equal address wins, and its match flag is set when the write is taken.
module match_cam #(
    parameter int ADDR_W = 30,
    parameter int DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           set,
    input  logic [$clog2(DEPTH):0]         n,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]   tbl_addr,
    output logic                           hit,
    output logic [$clog2(DEPTH)-1:0]       hit_idx,
    output logic [$clog2(DEPTH):0]         match_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] flags;
    logic [DEPTH-1:0] cand;

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = (CNT_W'(i) < n) && !flags[i] && (tbl_addr[i] == addr);
        end
    end

    // Scan from the top so the lowest candidate index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            flags     <= '0;
            match_cnt <= '0;
        end else if (set && hit) begin
            flags[hit_idx] <= 1'b1;
            match_cnt      <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/result_monitor.sv
// Result monitor: checks a snooped write stream against a loadable expected table,
// counting mismatches and missing entries, and flags completion or timeout.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 16,
    parameter int                ERR_W    = 8,
    parameter int                DUR_W    = 16,
    parameter int                TIMEOUT  = 10000,
    parameter logic [ADDR_W-1:0] END_ADDR = 30'h3FFF_FFFF,
    parameter int                ORDERED  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_count,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wen,
    output logic [ERR_W-1:0]         error_num,
    output logic [DUR_W-1:0]         duration,
    output logic                     finish,
    output logic                     timeout,
    output logic                     busy
);
    localparam int               IDX_W    = $clog2(DEPTH);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [31:0]      ERR_MAX  = 32'({ERR_W{1'b1}});
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(TIMEOUT - 1);

    state_t                       state, state_n;
    logic [CNT_W-1:0]             n, n_n, ptr, ptr_n;
    logic [CNT_W-1:0]             n_start, consumed, missing;
    logic [ERR_W-1:0]             err, err_n, err_bulk, err_inc;
    logic [DUR_W-1:0]             dur, dur_n;
    logic [DEPTH-1:0][ADDR_W-1:0] tbl_addr;
    logic [DEPTH-1:0][DATA_W-1:0] tbl_data;
    logic                         cam_hit;
    logic [IDX_W-1:0]             cam_idx;
    logic [CNT_W-1:0]             cam_cnt;
    logic                         is_end, tmo_hit, ord_bad, any_bad;

    // Expected table is plain storage; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    assign n_start  = (cfg_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_count;
    assign is_end   = wen && (addr == END_ADDR);
    assign tmo_hit  = (dur == DUR_LAST);
    assign ord_bad  = (tbl_addr[ptr[IDX_W-1:0]] != addr) || (tbl_data[ptr[IDX_W-1:0]] != data);
    assign any_bad  = (tbl_data[cam_idx] != data);
    assign consumed = (ORDERED != 0) ? ptr : cam_cnt;
    assign missing  = n - consumed;
    assign err_bulk = ERR_W'(sat_add(32'(err), 32'(missing), ERR_MAX));
    assign err_inc  = ERR_W'(sat_add(32'(err), 32'd1, ERR_MAX));

    generate
        if (ORDERED == 0) begin : g_cam
            logic cam_clr, cam_set;
            assign cam_clr = (state == IDLE) && start;
            assign cam_set = (state == RUN) && wen && !is_end && !tmo_hit;
            match_cam #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cam (
                .clk       (clk),
                .rst       (rst),
                .clr       (cam_clr),
                .set       (cam_set),
                .n         (n),
                .addr      (addr),
                .tbl_addr  (tbl_addr),
                .hit       (cam_hit),
                .hit_idx   (cam_idx),
                .match_cnt (cam_cnt)
            );
        end else begin : g_no_cam
            assign cam_hit = 1'b0;
            assign cam_idx = '0;
            assign cam_cnt = '0;
        end
    endgenerate

    always_comb begin
        state_n = state;
        n_n     = n;
        ptr_n   = ptr;
        err_n   = err;
        dur_n   = dur;
        unique case (state)
            IDLE: begin
                if (start) begin
                    n_n     = n_start;
                    ptr_n   = '0;
                    err_n   = '0;
                    dur_n   = '0;
                    state_n = (n_start == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                dur_n = dur + DUR_W'(1);
                // Timeout wins over a write arriving on the same edge.
                if (tmo_hit) begin
                    state_n = TOUT;
                    err_n   = err_bulk;
                end else if (is_end) begin
                    state_n = DONE;
                    err_n   = err_bulk;
                end else if (wen) begin
                    if (ORDERED != 0) begin
                        ptr_n = ptr + CNT_W'(1);
                        if (ord_bad) err_n = err_inc;
                        if (ptr_n == n) state_n = DONE;
                    end else if (cam_hit) begin
                        if (any_bad) err_n = err_inc;
                        if (cam_cnt + CNT_W'(1) == n) state_n = DONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n     <= '0;
            ptr   <= '0;
            err   <= '0;
            dur   <= '0;
        end else begin
            state <= state_n;
            n     <= n_n;
            ptr   <= ptr_n;
            err   <= err_n;
            dur   <= dur_n;
        end
    end

    assign error_num = err;
    assign duration  = dur;
    assign finish    = (state == DONE) || (state == TOUT);
    assign timeout   = (state == TOUT);
    assign busy      = (state == RUN);

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: four differently parameterised instances share one
// stimulus stream; results are compared against a transaction-level model.
module tb_result_monitor;
    localparam logic [29:0] END_A = 30'h3FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, wen;
    logic [3:0]  cfg_idx;
    logic [29:0] cfg_addr, addr;
    logic [31:0] cfg_data, data;
    logic [4:0]  cfg_count;
    logic [7:0]  err0, err1, err2;
    logic [1:0]  err3;
    logic [15:0] dur_v [4];
    logic [3:0]  fin_v, tmo_v, busy_v;

    int checks = 0;
    int passes = 0;

    logic [29:0] ta [16];
    logic [31:0] td [16];
    int          cnt;
    int          sk [$];
    logic [29:0] sa [$];
    logic [31:0] sd [$];

    always #5 clk = ~clk;

    // 0: in-order defaults, 1: any-order, 2: TIMEOUT=20, 3: ERR_W=2
    result_monitor u_ord (.clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .addr(addr), .data(data), .wen(wen), .error_num(err0), .duration(dur_v[0]),
        .finish(fin_v[0]), .timeout(tmo_v[0]), .busy(busy_v[0]));
    result_monitor #(.ORDERED(0)) u_any (.clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .addr(addr), .data(data), .wen(wen), .error_num(err1), .duration(dur_v[1]),
        .finish(fin_v[1]), .timeout(tmo_v[1]), .busy(busy_v[1]));
    result_monitor #(.TIMEOUT(20)) u_tmo (.clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .addr(addr), .data(data), .wen(wen), .error_num(err2), .duration(dur_v[2]),
        .finish(fin_v[2]), .timeout(tmo_v[2]), .busy(busy_v[2]));
    result_monitor #(.ERR_W(2)) u_sat (.clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .addr(addr), .data(data), .wen(wen), .error_num(err3), .duration(dur_v[3]),
        .finish(fin_v[3]), .timeout(tmo_v[3]), .busy(busy_v[3]));

    function automatic int err_of(input int u);
        case (u)
            0:       return int'(err0);
            1:       return int'(err1);
            2:       return int'(err2);
            default: return int'(err3);
        endcase
    endfunction

    function automatic int ord_of(input int u); return (u == 1) ? 0 : 1; endfunction
    function automatic int tmo_of(input int u); return (u == 2) ? 20 : 10000; endfunction
    function automatic int ew_of(input int u);  return (u == 3) ? 2 : 8; endfunction

    // Transaction-level reference: walk the scheduled writes in time order.
    function automatic void model(input int u, output int e, output int d, output bit to);
        int n, ptr, hits, tmo, j;
        bit done;
        bit used [16];
        n = (cnt > 16) ? 16 : cnt;
        tmo = tmo_of(u);
        ptr = 0; hits = 0; done = 0;
        e = 0; d = 0; to = 0;
        for (int i = 0; i < 16; i++) used[i] = 0;
        if (n == 0) return;
        for (int i = 0; i < sk.size(); i++) begin
            if (sk[i] >= tmo) break;
            if (sa[i] == END_A) begin
                e += n - ((ord_of(u) != 0) ? ptr : hits);
                d = sk[i]; done = 1;
                break;
            end
            if (ord_of(u) != 0) begin
                if (sa[i] != ta[ptr] || sd[i] != td[ptr]) e++;
                ptr++;
                if (ptr == n) begin d = sk[i]; done = 1; break; end
            end else begin
                j = -1;
                for (int q = 0; q < n; q++) if (j < 0 && !used[q] && ta[q] == sa[i]) j = q;
                if (j >= 0) begin
                    used[j] = 1; hits++;
                    if (sd[i] != td[j]) e++;
                    if (hits == n) begin d = sk[i]; done = 1; break; end
                end
            end
        end
        if (!done) begin
            to = 1; d = tmo;
            e += n - ((ord_of(u) != 0) ? ptr : hits);
        end
        if (e > (1 << ew_of(u)) - 1) e = (1 << ew_of(u)) - 1;
    endfunction

    task automatic tick; @(posedge clk); #1; endtask

    task automatic idle_inputs;
        cfg_we = 0; start = 0; wen = 0; cfg_idx = '0;
        cfg_addr = '0; cfg_data = '0; addr = '0; data = '0;
    endtask

    task automatic do_reset;
        idle_inputs(); rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic load_table(input int c);
        for (int i = 0; i < 16; i++) begin
            cfg_we = 1; cfg_idx = 4'(i); cfg_addr = ta[i]; cfg_data = td[i]; tick();
        end
        cfg_we = 0; cfg_count = 5'(c); cnt = c;
    endtask

    task automatic seq_table(input int base_data);
        for (int i = 0; i < 16; i++) begin ta[i] = 30'h10 + 30'(i); td[i] = 32'(base_data + i); end
    endtask

    task automatic start_run(input bit w, input logic [29:0] a, input logic [31:0] d);
        start = 1; wen = w; addr = a; data = d; tick(); start = 0; wen = 0;
    endtask

    task automatic clear_sched; sk.delete(); sa.delete(); sd.delete(); endtask

    task automatic add_w(input int k, input logic [29:0] a, input logic [31:0] d);
        sk.push_back(k); sa.push_back(a); sd.push_back(d);
    endtask

    // Cycle k means the k-th rising edge after the start edge; who < 0 waits for all.
    task automatic drive_writes(input int who);
        int k, i;
        k = 1; i = 0;
        while (i < sk.size()) begin
            if (sk[i] == k) begin wen = 1; addr = sa[i]; data = sd[i]; i++; end
            tick(); wen = 0; k++;
        end
        for (int c = 0; c < 100; c++) begin
            if ((who < 0) ? (fin_v == 4'hF) : fin_v[who]) break;
            tick();
        end
    endtask

    task automatic test_reset;
        do_reset();
        for (int u = 0; u < 4; u++) begin
            checks++; if (err_of(u) !== 0) $display("FAIL reset_err[%0d] got %0d want 0", u, err_of(u)); else passes++;
            checks++; if (dur_v[u] !== 16'd0) $display("FAIL reset_dur[%0d] got %0d want 0", u, dur_v[u]); else passes++;
            checks++; if (fin_v[u] !== 1'b0) $display("FAIL reset_finish[%0d] got %b want 0", u, fin_v[u]); else passes++;
            checks++; if (tmo_v[u] !== 1'b0) $display("FAIL reset_timeout[%0d] got %b want 0", u, tmo_v[u]); else passes++;
            checks++; if (busy_v[u] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", u, busy_v[u]); else passes++;
        end
    endtask

    task automatic test_inorder_ok;
        do_reset(); seq_table(1); load_table(4);
        clear_sched();
        for (int i = 0; i < 4; i++) add_w(1 + 3 * i, ta[i], td[i]);
        start_run(0, '0, '0);
        drive_writes(0);
        checks++; if (fin_v[0] !== 1'b1) $display("FAIL inorder_finish got %b want 1", fin_v[0]); else passes++;
        checks++; if (err0 !== 8'd0) $display("FAIL inorder_err got %0d want 0", err0); else passes++;
        checks++; if (tmo_v[0] !== 1'b0) $display("FAIL inorder_timeout got %b want 0", tmo_v[0]); else passes++;
        checks++; if (dur_v[0] !== 16'd10) $display("FAIL inorder_dur got %0d want 10", dur_v[0]); else passes++;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL inorder_busy got %b want 0", busy_v[0]); else passes++;
    endtask

    task automatic test_inorder_err_end;
        do_reset(); seq_table(1); load_table(4);
        clear_sched();
        add_w(1, 30'h10, 32'd1); add_w(2, 30'h11, 32'd9); add_w(3, 30'h12, 32'd3); add_w(4, END_A, 32'd0);
        start_run(0, '0, '0);
        drive_writes(0);
        checks++; if (err0 !== 8'd2) $display("FAIL end_marker_err got %0d want 2", err0); else passes++;
        checks++; if (fin_v[0] !== 1'b1) $display("FAIL end_marker_finish got %b want 1", fin_v[0]); else passes++;
        checks++; if (dur_v[0] !== 16'd4) $display("FAIL end_marker_dur got %0d want 4", dur_v[0]); else passes++;
    endtask

    task automatic test_anyorder;
        do_reset(); seq_table(1); load_table(4);
        clear_sched();
        add_w(1, 30'h13, 32'd4); add_w(2, 30'h50, 32'd7); add_w(3, 30'h11, 32'd2);
        add_w(4, 30'h10, 32'd1); add_w(5, 30'h12, 32'd3);
        start_run(0, '0, '0);
        drive_writes(1);
        checks++; if (fin_v[1] !== 1'b1) $display("FAIL anyorder_finish got %b want 1", fin_v[1]); else passes++;
        checks++; if (err1 !== 8'd0) $display("FAIL anyorder_err got %0d want 0", err1); else passes++;
        checks++; if (dur_v[1] !== 16'd5) $display("FAIL anyorder_dur got %0d want 5", dur_v[1]); else passes++;
    endtask

    task automatic test_timeout;
        do_reset(); seq_table(1); load_table(4);
        clear_sched();
        add_w(1, 30'h10, 32'd1); add_w(20, 30'h11, 32'd2);
        start_run(0, '0, '0);
        drive_writes(2);
        checks++; if (tmo_v[2] !== 1'b1) $display("FAIL timeout_flag got %b want 1", tmo_v[2]); else passes++;
        checks++; if (fin_v[2] !== 1'b1) $display("FAIL timeout_finish got %b want 1", fin_v[2]); else passes++;
        checks++; if (dur_v[2] !== 16'd20) $display("FAIL timeout_dur got %0d want 20", dur_v[2]); else passes++;
        checks++; if (err2 !== 8'd3) $display("FAIL timeout_err got %0d want 3", err2); else passes++;
    endtask

    task automatic test_saturation;
        do_reset(); seq_table(1); load_table(8);
        clear_sched();
        for (int i = 0; i < 8; i++) add_w(1 + i, ta[i], td[i] + 32'd100);
        start_run(0, '0, '0);
        drive_writes(3);
        checks++; if (err3 !== 2'd3) $display("FAIL sat_err got %0d want 3", err3); else passes++;
        checks++; if (fin_v[3] !== 1'b1) $display("FAIL sat_finish got %b want 1", fin_v[3]); else passes++;
        checks++; if (err0 !== 8'd8) $display("FAIL sat_wide_err got %0d want 8", err0); else passes++;
    endtask

    task automatic test_count_zero;
        do_reset(); seq_table(1); load_table(0);
        start_run(0, '0, '0);
        checks++; if (fin_v[0] !== 1'b1) $display("FAIL zero_finish got %b want 1", fin_v[0]); else passes++;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL zero_busy got %b want 0", busy_v[0]); else passes++;
        checks++; if (dur_v[0] !== 16'd0) $display("FAIL zero_dur got %0d want 0", dur_v[0]); else passes++;
    endtask

    task automatic test_count_clamp;
        do_reset(); seq_table(1); load_table(31);
        clear_sched();
        for (int i = 0; i < 15; i++) add_w(1 + i, ta[i], td[i]);
        add_w(16, END_A, 32'd0);
        start_run(0, '0, '0);
        drive_writes(0);
        checks++; if (err0 !== 8'd1) $display("FAIL clamp_err got %0d want 1", err0); else passes++;
        checks++; if (dur_v[0] !== 16'd16) $display("FAIL clamp_dur got %0d want 16", dur_v[0]); else passes++;
        checks++; if (err1 !== 8'd1) $display("FAIL clamp_any_err got %0d want 1", err1); else passes++;
    endtask

    task automatic test_reset_mid_run;
        do_reset(); seq_table(1); load_table(4);
        start_run(0, '0, '0);
        wen = 1; addr = 30'h10; data = 32'd55; tick(); wen = 0; tick();
        checks++; if (busy_v[0] !== 1'b1) $display("FAIL midrun_busy got %b want 1", busy_v[0]); else passes++;
        checks++; if (err0 !== 8'd1) $display("FAIL midrun_err got %0d want 1", err0); else passes++;
        rst = 1; tick();
        for (int u = 0; u < 4; u++) begin
            checks++;
            if ({err_of(u) != 0, dur_v[u] != 16'd0, fin_v[u], tmo_v[u], busy_v[u]} !== 5'b0)
                $display("FAIL midrun_reset[%0d] got err=%0d dur=%0d fin=%b tmo=%b busy=%b want all 0",
                         u, err_of(u), dur_v[u], fin_v[u], tmo_v[u], busy_v[u]);
            else passes++;
        end
        rst = 0;
    endtask

    task automatic test_ignored_inputs;
        do_reset(); seq_table(1); load_table(4);
        start_run(1, 30'h10, 32'hBAD);
        cfg_we = 1; cfg_idx = 4'd0; cfg_addr = 30'h77; cfg_data = 32'h99; start = 1; tick();
        cfg_we = 0; start = 0;
        clear_sched();
        for (int i = 0; i < 4; i++) add_w(1 + i, ta[i], td[i]);
        drive_writes(0);
        checks++; if (err0 !== 8'd0) $display("FAIL ignore_err got %0d want 0", err0); else passes++;
        checks++; if (dur_v[0] !== 16'd5) $display("FAIL ignore_dur got %0d want 5", dur_v[0]); else passes++;
        do_reset();
        start_run(0, '0, '0);
        drive_writes(0);
        checks++; if (fin_v[0] !== 1'b1) $display("FAIL table_kept_finish got %b want 1", fin_v[0]); else passes++;
        checks++; if (err0 !== 8'd0) $display("FAIL table_kept_err got %0d want 0", err0); else passes++;
        checks++; if (dur_v[0] !== 16'd4) $display("FAIL table_kept_dur got %0d want 4", dur_v[0]); else passes++;
    endtask

    task automatic test_random;
        for (int r = 0; r < 12; r++) begin
            int c, nn, k, nxt, sel, j, e, d;
            bit to;
            do_reset();
            for (int i = 0; i < 16; i++) begin
                ta[i] = 30'h20 + 30'($urandom_range(0, 7));
                td[i] = 32'($urandom_range(0, 3));
            end
            if (r % 4 == 3) c = $urandom_range(17, 31);
            else if ($urandom_range(0, 9) == 0) c = 0;
            else c = $urandom_range(1, 8);
            load_table(c);
            nn = (c > 16) ? 16 : ((c == 0) ? 1 : c);
            clear_sched();
            k = 0; nxt = 0;
            for (int w = 0; w < nn + 2; w++) begin
                k += $urandom_range(1, 3);
                sel = $urandom_range(0, 9);
                if (sel < 2) add_w(k, 30'h60 + 30'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                else begin
                    j = (sel < 6) ? (nxt % nn) : $urandom_range(0, nn - 1);
                    nxt++;
                    add_w(k, ta[j], (sel == 9) ? (td[j] ^ 32'd1) : td[j]);
                end
            end
            add_w(k + $urandom_range(1, 3), END_A, 32'd0);
            start_run(0, '0, '0);
            drive_writes(-1);
            for (int u = 0; u < 4; u++) begin
                model(u, e, d, to);
                checks++; if (err_of(u) !== e) $display("FAIL rand%0d_err[%0d] got %0d want %0d", r, u, err_of(u), e); else passes++;
                checks++; if (dur_v[u] !== 16'(d)) $display("FAIL rand%0d_dur[%0d] got %0d want %0d", r, u, dur_v[u], d); else passes++;
                checks++; if (tmo_v[u] !== to) $display("FAIL rand%0d_timeout[%0d] got %b want %b", r, u, tmo_v[u], to); else passes++;
                checks++; if (fin_v[u] !== 1'b1) $display("FAIL rand%0d_finish[%0d] got %b want 1", r, u, fin_v[u]); else passes++;
            end
        end
    endtask

    initial begin
        rst = 1; cfg_count = '0; cnt = 0;
        idle_inputs();
        test_reset();
        test_inorder_ok();
        test_inorder_err_end();
        test_anyorder();
        test_timeout();
        test_saturation();
        test_count_zero();
        test_count_clamp();
        test_reset_mid_run();
        test_ignored_inputs();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
